bus_arbiter16: RTL and testbench
================================

// Module: bus_arbiter16
// PURPOSE
//   Round-robin arbiter and sequencer for a shared 16-bit datapath. Up to NREQ
//   requesters compete for one registered 16-bit output bus, which feeds the
//   shared register/memory write port. The block issues one-hot grants and
//   steers the owner's data word through an internal 16-bit mux tree. It
//   limits tenure to MAX_HOLD cycles whenever other requesters are waiting.
// PARAMETERS
//   NREQ      4   number of requesters, 2..8
//   IDXW      2   owner index width, >= clog2(NREQ)
//   MAX_HOLD  8   max grant cycles while others pend, 1..255
// PORTS
//   clock      in   1          sole clock, rising edge
//   reset      in   1          synchronous, active-high
//   req        in   NREQ       request, one bit per requester; held high to keep bus
//   data       in   16*NREQ    requester i word in data[16*i+15:16*i]
//   gnt        out  NREQ       one-hot grant, registered
//   owner      out  IDXW       index of current/last owner, registered
//   out        out  16         shared bus word, registered
//   out_valid  out  1          out carries a word accepted in previous cycle
// BEHAVIOUR
//   Clocking and reset
//   - One clock; reset is synchronous and active-high, overrides all.
//   - Reset values: gnt=0, owner=0, out=16'h0000, out_valid=0.
//   - Reset values (internal): state=IDLE, rr_ptr=0, hold_cnt=0.
//   States: IDLE, GRANT.
//   IDLE
//   - If no req: stay; gnt=0.
//   - If any req: the winner is the first i with req[i]=1, scanning from rr_ptr
//     upward with wrap NREQ-1 -> 0.
//   - On the same edge: gnt<=onehot(i), owner<=i, hold_cnt<=1, state<=GRANT.
//   GRANT (o = owner)
//   - Sampling: every edge with req[o]=1 does out<=data[o] and out_valid<=1.
//   - Latency: a word driven in cycle t appears on out after edge t+1.
//   - Release: at an edge with req[o]=0: gnt<=0, out_valid<=0, out holds,
//     rr_ptr<=(o+1) mod NREQ, state<=IDLE.
//   - Forced release: at an edge with req[o]=1, hold_cnt==MAX_HOLD, and any
//     other req[j] high (j!=o): word still sampled (out_valid<=1). gnt<=0,
//     rr_ptr<=(o+1) mod NREQ, state<=IDLE.
//   - Otherwise: hold_cnt<=min(hold_cnt+1, MAX_HOLD). It saturates, so a lone
//     requester keeps the bus indefinitely.
//   Turnaround and validity
//   - Every release spends >= 1 cycle in IDLE with gnt=0: a bus turnaround
//     bubble, so two grants are never adjacent.
//   - out_valid is 0 on every edge not sampling in GRANT.
//   Invariants and boundaries
//   - gnt always zero or one-hot.
//   - out changes only when out_valid<=1.
//   - req bits of non-owners are ignored during GRANT.
//   - A non-owner whose req drops before being granted is simply skipped.
//   - rr_ptr wraps NREQ-1 -> 0.
//   - Reset asserted mid-GRANT: the next edge applies reset values; any
//     in-flight word is dropped.
// TESTING
//   1 Reset: reset=1 for 2 edges with req=4'b1111 -> gnt=0, out=0, out_valid=0.
//     Then release reset -> gnt=4'b0001 one edge later.
//   2 Single: req=4'b0100, data2=16'hBEEF -> gnt=4'b0100 at edge 1.
//     out=BEEF, out_valid=1 at edge 2. Drop req -> gnt=0, out_valid=0 next edge.
//   3 Fairness: req=4'b1111 held, MAX_HOLD=8 -> owners 0,1,2,3,0.
//     Each owner gets 8 valid words, separated by a 1-cycle gnt=0 gap.
//   4 Saturation: only req[1] held 20 cycles -> gnt=4'b0010 throughout.
//     20 consecutive out_valid.
//   5 Wrap: owner 3 releases with req=4'b0001 pending -> IDLE 1 cycle, then gnt=4'b0001.
//   6 Mid-grant reset: reset at 3rd grant cycle -> all outputs at reset values next edge.
//     Then req=4'b0010 -> grant to 1, since rr_ptr was restored to 0 and 1 is the
//     first requester found.

Source files
------------

// File: rtl/bus_arbiter16.sv
// Round-robin arbiter for a shared, registered 16-bit bus with bounded tenure.
// One-hot grants, an owner index and a steered data word, all registered.
module bus_arbiter16 #(
    parameter int NREQ     = 4,
    parameter int IDXW     = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   data,
    output logic [NREQ-1:0]      gnt,
    output logic [IDXW-1:0]      owner,
    output logic [15:0]          out,
    output logic                 out_valid
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};

    logic [0:0]      state_q,     state_d;
    logic [IDXW-1:0] rr_ptr_q,    rr_ptr_d;
    logic [7:0]      hold_cnt_q,  hold_cnt_d;
    logic [NREQ-1:0] gnt_q,       gnt_d;
    logic [IDXW-1:0] owner_q,     owner_d;
    logic [15:0]     out_q,       out_d;
    logic            out_valid_q, out_valid_d;

    logic [IDXW-1:0] winner;
    logic            any_req;
    logic [15:0]     owner_word;
    logic            owner_req;
    logic            others_req;
    logic [IDXW-1:0] next_ptr;

    // Scan from rr_ptr upward with wrap; the first asserted request wins.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = IDXW'(idx);
            end
        end
    end

    always_comb begin
        owner_word = '0;
        owner_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IDXW'(i)) begin
                owner_word = data[16*i +: 16];
                owner_req  = req[i];
            end
        end
    end

    assign others_req = |(req & ~gnt_q);
    assign next_ptr   = (owner_q == IDXW'(NREQ-1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        out_d       = out_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (any_req) begin
                    gnt_d      = ONE_HOT_0 << winner;
                    owner_d    = winner;
                    hold_cnt_d = 8'd1;
                    state_d    = ST_GRANT;
                end
            end
            default: begin
                if (!owner_req) begin
                    gnt_d    = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end else begin
                    out_d       = owner_word;
                    out_valid_d = 1'b1;
                    if (hold_cnt_q == 8'(MAX_HOLD) && others_req) begin
                        gnt_d    = '0;
                        rr_ptr_d = next_ptr;
                        state_d  = ST_IDLE;
                    end else if (hold_cnt_q < 8'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            gnt_q       <= '0;
            owner_q     <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bus_arbiter16.sv
// Directed bench for bus_arbiter16: reset, single grant, fairness, saturation,
// pointer wrap and mid-grant reset, with hand-computed expectations.
module tb_bus_arbiter16;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] data;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic [15:0] out;
    logic        out_valid;

    int errors = 0;
    int checks = 0;
    int seq [5] = '{0, 1, 2, 3, 0};

    bus_arbiter16 #(.NREQ(4), .IDXW(2), .MAX_HOLD(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .owner     (owner),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        return 32'(16'h1111 * (i + 1));
    endfunction

    initial begin
        reset = 1'b1;
        req   = 4'b1111;
        data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        // Reset held for two edges with all requests high
        tick();
        tick();
        check("rst_gnt",   32'(gnt), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_out",   32'(out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);

        reset = 1'b0;
        tick();
        check("post_rst_gnt", 32'(gnt), 32'h1);
        check("post_rst_valid", 32'(out_valid), 32'h0);

        // Fairness: 8 words per owner, one-cycle gap between tenures
        for (int s = 0; s < 5; s++) begin
            int o;
            o = seq[s];
            check("fair_gnt",   32'(gnt), 32'(1) << o);
            check("fair_owner", 32'(owner), 32'(o));
            for (int k = 1; k <= 8; k++) begin
                tick();
                check("fair_valid", 32'(out_valid), 32'h1);
                check("fair_out",   32'(out), word(o));
                check("fair_tenure_gnt", 32'(gnt), (k < 8) ? (32'(1) << o) : 32'h0);
            end
            tick();
            check("fair_gap_valid", 32'(out_valid), 32'h0);
            check("fair_gap_hold",  32'(out), word(o));
        end
        check("fair_next_gnt", 32'(gnt), 32'h2);

        req = 4'b0000;
        tick();
        check("rel1_gnt",   32'(gnt), 32'h0);
        check("rel1_valid", 32'(out_valid), 32'h0);
        tick();
        check("idle_gnt", 32'(gnt), 32'h0);

        // Single requester 2 with BEEF
        data[47:32] = 16'hBEEF;
        req = 4'b0100;
        tick();
        check("single_gnt",   32'(gnt), 32'h4);
        check("single_owner", 32'(owner), 32'h2);
        check("single_valid0", 32'(out_valid), 32'h0);
        tick();
        check("single_out",   32'(out), 32'hBEEF);
        check("single_valid", 32'(out_valid), 32'h1);
        req = 4'b0000;
        tick();
        check("single_rel_gnt",   32'(gnt), 32'h0);
        check("single_rel_valid", 32'(out_valid), 32'h0);
        check("single_rel_out",   32'(out), 32'hBEEF);

        // Saturation: lone requester 1 keeps the bus for 20 cycles
        req = 4'b0010;
        tick();
        check("sat_gnt0",  32'(gnt), 32'h2);
        check("sat_owner", 32'(owner), 32'h1);
        for (int k = 0; k < 20; k++) begin
            data[31:16] = 16'h5000 + 16'(k);
            tick();
            check("sat_gnt",   32'(gnt), 32'h2);
            check("sat_valid", 32'(out_valid), 32'h1);
            check("sat_out",   32'(out), 32'h5000 + 32'(k));
        end
        req = 4'b0000;
        tick();
        check("sat_rel_gnt", 32'(gnt), 32'h0);

        // Wrap: owner 3 releases with requester 0 pending
        req = 4'b1000;
        tick();
        check("wrap_gnt3",  32'(gnt), 32'h8);
        check("wrap_owner3", 32'(owner), 32'h3);
        tick();
        check("wrap_out3", 32'(out), 32'h4444);
        req = 4'b0001;
        tick();
        check("wrap_gap_gnt",   32'(gnt), 32'h0);
        check("wrap_gap_valid", 32'(out_valid), 32'h0);
        tick();
        check("wrap_gnt0",   32'(gnt), 32'h1);
        check("wrap_owner0", 32'(owner), 32'h0);

        // Mid-grant reset with rr_ptr parked at 3
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        check("mr_gnt2", 32'(gnt), 32'h4);
        req = 4'b0000;
        tick();
        req = 4'b1000;
        tick();
        check("mr_gnt3", 32'(gnt), 32'h8);
        tick();
        check("mr_valid_pre", 32'(out_valid), 32'h1);
        data[63:48] = 16'hDEAD;
        reset = 1'b1;
        tick();
        check("mr_gnt",   32'(gnt), 32'h0);
        check("mr_owner", 32'(owner), 32'h0);
        check("mr_out",   32'(out), 32'h0);
        check("mr_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        req = 4'b1010;
        tick();
        check("mr_regrant_gnt",   32'(gnt), 32'h2);
        check("mr_regrant_owner", 32'(owner), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
